bcd_seg7_scan: RTL and testbench

Multiplexed 3-digit seven-segment display driver, directly downstream of the 8-bit binary-to-BCD converter. It captures a 10-bit packed BCD value (2-bit hundreds, 4-bit tens, 4-bit ones) and time-multiplexes it onto three common-anode digits. It applies leading-zero blanking and swaps in new values only at scan-frame boundaries, so a display frame never mixes old and new digits.

---
 rtl/bcd_seg7_scan.sv | 139 +++++++++++++
 tb/tb_bcd_seg7_scan.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: three-digit multiplexed seven-segment driver for common-anode
// displays. A packed BCD value is staged in a pending register and only moves
// into the displayed register at the end of a full scan frame, so one frame
// never shows a mix of old and new digits.
module bcd_seg7_scan #(
  parameter int CLK_DIV  = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] bcd_in,
  input  logic       load,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       upd
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    DIG_ONES     = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_t;

  logic [CW-1:0] cnt, cnt_nxt;
  digit_t        idx, idx_nxt;
  logic [9:0]    pend, disp, disp_nxt;
  logic          pend_v;
  logic          cnt_wrap, frame_end, swap;

  logic [1:0] hund;
  logic [3:0] tens, ones;
  logic [3:0] digit_val;
  logic       digit_dash, digit_blank;
  logic [6:0] seg_dec, seg_nxt;
  logic [2:0] an_nxt;

  // Divider and digit index advance; a frame ends when the index leaves the hundreds digit.
  always_comb begin
    cnt_wrap  = (cnt == CNT_LAST);
    cnt_nxt   = cnt_wrap ? '0 : cnt + CW'(1);
    idx_nxt   = idx;
    if (cnt_wrap) begin
      case (idx)
        DIG_ONES: idx_nxt = DIG_TENS;
        DIG_TENS: idx_nxt = DIG_HUNDREDS;
        default:  idx_nxt = DIG_ONES;
      endcase
    end
    frame_end = cnt_wrap && (idx == DIG_HUNDREDS);
    swap      = frame_end && pend_v;
    disp_nxt  = swap ? pend : disp;
  end

  // Select and decode the digit that will be lit after this edge, so an/seg move together with idx.
  always_comb begin
    hund        = disp_nxt[9:8];
    tens        = disp_nxt[7:4];
    ones        = disp_nxt[3:0];
    digit_val   = ones;
    digit_dash  = 1'b0;
    digit_blank = 1'b0;
    case (idx_nxt)
      DIG_ONES: begin
        digit_val  = ones;
        digit_dash = (ones > 4'd9);
      end
      DIG_TENS: begin
        digit_val   = tens;
        digit_dash  = (tens > 4'd9);
        digit_blank = BLANK_LZ && (hund == 2'd0) && (tens == 4'd0);
      end
      default: begin
        digit_val   = {2'b00, hund};
        digit_dash  = (hund == 2'd3);
        digit_blank = BLANK_LZ && (hund == 2'd0);
      end
    endcase

    case (digit_val)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
    if (digit_dash) begin
      seg_dec = 7'h3F;
    end

    case (idx_nxt)
      DIG_ONES: an_nxt = 3'b110;
      DIG_TENS: an_nxt = 3'b101;
      default:  an_nxt = 3'b011;
    endcase

    seg_nxt = seg_dec;
    if (digit_blank) begin
      an_nxt  = 3'b111;
      seg_nxt = 7'h7F;
    end
  end

  // State and registered outputs; a load on the frame-end edge refills pend after the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= DIG_ONES;
      pend   <= '0;
      pend_v <= 1'b0;
      disp   <= '0;
      an     <= 3'b111;
      seg    <= 7'h7F;
      upd    <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      idx  <= idx_nxt;
      disp <= disp_nxt;
      if (load) begin
        pend   <= bcd_in;
        pend_v <= 1'b1;
      end else if (swap) begin
        pend_v <= 1'b0;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      upd <= swap;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb_bcd_seg7_scan: drives two instances (leading-zero blanking on and off)
// with shared inputs and compares them against a cycle-count based model.
module tb_bcd_seg7_scan;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 3 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [9:0] bcd_in;
  logic [2:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  logic       upd, upd_nb;

  // Reference state: k counts edges since the last reset edge.
  int         k;
  logic [9:0] m_pend, m_disp;
  bit         m_pend_v;
  logic [2:0] e_an, e_an_nb;
  logic [6:0] e_seg, e_seg_nb;
  logic       e_upd;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_seg7_scan #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .an(an), .seg(seg), .upd(upd)
  );

  bcd_seg7_scan #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .an(an_nb), .seg(seg_nb), .upd(upd_nb)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Expected {an, seg} for a digit position of a BCD value.
  function automatic logic [9:0] exp_out(input int digit, input logic [9:0] v, input bit blank_lz);
    logic [6:0] tbl [10];
    logic [2:0] a;
    int h, t, o, val;
    bit dash, blank;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    h = int'(v[9:8]);
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (digit == 0) begin
      val = o; dash = (o > 9); blank = 1'b0;
    end else if (digit == 1) begin
      val = t; dash = (t > 9); blank = blank_lz && (h == 0) && (t == 0);
    end else begin
      val = h; dash = (h == 3); blank = blank_lz && (h == 0);
    end
    if (blank) return {3'b111, 7'h7F};
    a = ~(3'b001 << digit);
    return {a, (dash ? 7'h3F : tbl[val])};
  endfunction

  // Apply one cycle of inputs, advance the reference model on the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic l, input logic [9:0] b);
    logic [9:0] o;
    rst = r; load = l; bcd_in = b;
    @(posedge clk);
    if (r) begin
      k = 0; m_pend = '0; m_pend_v = 1'b0; m_disp = '0;
      e_upd = 1'b0; e_an = 3'b111; e_seg = 7'h7F; e_an_nb = 3'b111; e_seg_nb = 7'h7F;
    end else begin
      k++;
      e_upd = 1'b0;
      if ((k % FRAME) == 0 && m_pend_v) begin
        m_disp = m_pend; m_pend_v = 1'b0; e_upd = 1'b1;
      end
      if (l) begin
        m_pend = b; m_pend_v = 1'b1;
      end
      o = exp_out((k / CLK_DIV) % 3, m_disp, 1'b1);
      e_an = o[9:7]; e_seg = o[6:0];
      o = exp_out((k / CLK_DIV) % 3, m_disp, 1'b0);
      e_an_nb = o[9:7]; e_seg_nb = o[6:0];
    end
    #1;
  endtask

  // Reset values, first lit digit after release, blanked upper digits of value 0.
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 10'h0);
      n_checks++;
      if ({an, seg, upd} !== {3'b111, 7'h7F, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL reset_hold cyc%0d: got an=%b seg=%h upd=%b, want an=111 seg=7f upd=0", i, an, seg, upd);
      end
    end
    step(1'b0, 1'b0, 10'h0);
    n_checks++;
    if ({an, seg, upd} !== {3'b110, 7'h40, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got an=%b seg=%h upd=%b, want an=110 seg=40 upd=0", an, seg, upd);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 10'h0);
      n_checks++;
      if ({an, seg, upd, an_nb, seg_nb, upd_nb} !== {e_an, e_seg, e_upd, e_an_nb, e_seg_nb, e_upd}) begin
        n_fail++;
        $display("[TB] FAIL reset_scan k=%0d: got an=%b seg=%h upd=%b nb(an=%b seg=%h upd=%b), want an=%b seg=%h upd=%b nb(an=%b seg=%h)",
                 k, an, seg, upd, an_nb, seg_nb, upd_nb, e_an, e_seg, e_upd, e_an_nb, e_seg_nb);
      end
    end
  endtask

  // Load a value mid-frame, require an upd pulse within one frame, then follow two full frames.
  task automatic test_display(input string name, input logic [9:0] v);
    bit seen;
    step(1'b0, 1'b0, 10'h0);
    step(1'b0, 1'b1, v);
    seen = 1'b0;
    for (int i = 0; i < FRAME + 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 10'h0);
      if (upd === 1'b1) seen = 1'b1;
      n_checks++;
      if ({an, seg, upd, an_nb, seg_nb, upd_nb} !== {e_an, e_seg, e_upd, e_an_nb, e_seg_nb, e_upd}) begin
        n_fail++;
        $display("[TB] FAIL %s k=%0d: got an=%b seg=%h upd=%b nb(an=%b seg=%h upd=%b), want an=%b seg=%h upd=%b nb(an=%b seg=%h)",
                 name, k, an, seg, upd, an_nb, seg_nb, upd_nb, e_an, e_seg, e_upd, e_an_nb, e_seg_nb);
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL %s_upd: got no upd pulse, want one within %0d cycles", name, FRAME);
    end
  endtask

  // Load A on the edge before the boundary and B on the boundary edge itself.
  task automatic test_back_to_back();
    for (int i = 0; i < FRAME && (k % FRAME) != FRAME - 2; i++) step(1'b0, 1'b0, 10'h0);
    step(1'b0, 1'b1, 10'h246);
    step(1'b0, 1'b1, 10'h139);
    n_checks++;
    if ({upd, an, seg} !== {1'b1, 3'b110, 7'h02}) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: got upd=%b an=%b seg=%h, want upd=1 an=110 seg=02", upd, an, seg);
    end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b0, 10'h0);
      n_checks++;
      if ({an, seg, upd, an_nb, seg_nb, upd_nb} !== {e_an, e_seg, e_upd, e_an_nb, e_seg_nb, e_upd}) begin
        n_fail++;
        $display("[TB] FAIL b2b k=%0d: got an=%b seg=%h upd=%b nb(an=%b seg=%h upd=%b), want an=%b seg=%h upd=%b nb(an=%b seg=%h)",
                 k, an, seg, upd, an_nb, seg_nb, upd_nb, e_an, e_seg, e_upd, e_an_nb, e_seg_nb);
      end
    end
    n_checks++;
    if ({upd, an, seg} !== {1'b1, 3'b110, 7'h10}) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got upd=%b an=%b seg=%h, want upd=1 an=110 seg=10", upd, an, seg);
    end
  endtask

  // Reset with a value pending: it must never reach the display.
  task automatic test_reset_midframe();
    int upd_count;
    for (int i = 0; i < FRAME && (k % FRAME) != 2; i++) step(1'b0, 1'b0, 10'h0);
    step(1'b0, 1'b1, 10'h321);
    step(1'b0, 1'b0, 10'h0);
    step(1'b1, 1'b0, 10'h0);
    n_checks++;
    if ({an, seg, upd} !== {3'b111, 7'h7F, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL midreset: got an=%b seg=%h upd=%b, want an=111 seg=7f upd=0", an, seg, upd);
    end
    upd_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 10'h0);
      if (upd === 1'b1) upd_count++;
      n_checks++;
      if ({an, seg, upd, an_nb, seg_nb, upd_nb} !== {e_an, e_seg, e_upd, e_an_nb, e_seg_nb, e_upd}) begin
        n_fail++;
        $display("[TB] FAIL midreset_scan k=%0d: got an=%b seg=%h upd=%b nb(an=%b seg=%h upd=%b), want an=%b seg=%h upd=%b nb(an=%b seg=%h)",
                 k, an, seg, upd, an_nb, seg_nb, upd_nb, e_an, e_seg, e_upd, e_an_nb, e_seg_nb);
      end
    end
    n_checks++;
    if (upd_count != 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_upd: got %0d upd pulses, want 0", upd_count);
    end
  endtask

  // Random loads, values and occasional resets against the model.
  task automatic test_random();
    logic r, l;
    logic [9:0] b;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 7) == 0);
      b = 10'($urandom_range(0, 1023));
      step(r, l, b);
      n_checks++;
      if ({an, seg, upd, an_nb, seg_nb, upd_nb} !== {e_an, e_seg, e_upd, e_an_nb, e_seg_nb, e_upd}) begin
        n_fail++;
        $display("[TB] FAIL random k=%0d: got an=%b seg=%h upd=%b nb(an=%b seg=%h upd=%b), want an=%b seg=%h upd=%b nb(an=%b seg=%h)",
                 k, an, seg, upd, an_nb, seg_nb, upd_nb, e_an, e_seg, e_upd, e_an_nb, e_seg_nb);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = '0;
    test_reset();
    test_display("value_153", 10'h153);
    test_display("blank_007", 10'h007);
    test_display("interior_205", 10'h205);
    test_display("invalid_3ff", 10'h3FF);
    test_display("zero_000", 10'h000);
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
